// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with N read ports, write-through bypass,
// per-register pending-write scoreboard and a background clear sequencer.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    // state    | meaning
    // ST_IDLE  | normal operation, writes/reservations/clear requests accepted
    // ST_CLEAR | scrubbing regs[idx] and sb[idx], one register per cycle
    // ST_DONE  | single cycle announcing completion via clr_done
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0]   REG_LIM  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic [NREGS-1:0]  sb_q, sb_d;

    logic              idle;
    logic              wr_eff;
    logic              rsv_eff;
    logic [NRD*XLEN-1:0] rd_comb;

    // Register 0 (when hardwired) and out-of-range addresses behave as absent.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < REG_LIM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign idle    = (state_q == ST_IDLE);
    assign wr_eff  = idle && wr_en && addr_live(wr_addr);
    assign rsv_eff = idle && rsv_en && addr_live(rsv_addr);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = (state_q == ST_DONE);

    // Reservation is applied after the write so a same-cycle new producer wins.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (wr_eff) begin
            regs_d[wr_addr] = wr_data;
            sb_d[wr_addr]   = 1'b0;
        end
        if (rsv_eff) begin
            sb_d[rsv_addr] = 1'b1;
        end
        if (state_q == ST_CLEAR) begin
            regs_d[idx_q] = '0;
            sb_d[idx_q]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sb_q    <= '0;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sb_q    <= sb_d;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // wr_eff already excludes CLEAR/DONE, so bypass is naturally off while scrubbing.
    always_comb begin
        logic [AW-1:0] ra;
        rd_comb = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (addr_live(ra)) begin
                rd_comb[i*XLEN +: XLEN] = regs_q[ra];
                rd_busy[i]              = sb_q[ra];
                if ((BYPASS != 0) && wr_eff && (wr_addr == ra)) begin
                    rd_comb[i*XLEN +: XLEN] = wr_data;
                    rd_busy[i]              = 1'b0;
                end
            end
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;

        always_comb begin
            rd_data_d = rd_comb;
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_rd_comb
        assign rd_data = rd_comb;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: combinational-read and registered-read instances
// share stimulus and are checked every cycle against an array/queue-level model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rdr_data;
    logic [1:0]  rd_busy, rdr_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        clr_req;
    logic        clr_busy, clr_done, rdr_clr_busy, rdr_clr_done;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.READ_REG(0)) dut (
        .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_scoreboard #(.READ_REG(1)) dut_r (
        .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rdr_data),
        .rd_busy(rdr_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(rdr_clr_busy), .clr_done(rdr_clr_done)
    );

    // Model: register contents, pending bits, clear position (-1 when not clearing).
    logic [31:0] m_reg [32];
    logic        m_sb  [32];
    int          clr_pos = -1;
    bit          m_done  = 1'b0;
    logic [31:0] m_rdq [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void exp_port(input logic [4:0] a, output logic [31:0] d, output logic b);
        bit idle;
        idle = (clr_pos < 0) && !m_done;
        if (a == 5'd0) begin
            d = 32'd0; b = 1'b0;
        end else if (idle && wr_en && wr_addr == a) begin
            d = wr_data; b = 1'b0;
        end else begin
            d = m_reg[a]; b = m_sb[a];
        end
    endfunction

    initial forever begin
        logic [31:0] d;
        logic        b;
        @(posedge clk);
        if (!resetn) begin
            for (int k = 0; k < 32; k++) begin m_reg[k] = 32'd0; m_sb[k] = 1'b0; end
            clr_pos = -1; m_done = 1'b0; m_rdq[0] = 32'd0; m_rdq[1] = 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_port(rd_addr[i*5 +: 5], d, b);
                m_rdq[i] = d;
            end
            if (clr_pos >= 0) begin
                m_reg[clr_pos] = 32'd0; m_sb[clr_pos] = 1'b0;
                clr_pos++;
                if (clr_pos == 32) begin clr_pos = -1; m_done = 1'b1; end
            end else if (m_done) begin
                m_done = 1'b0;
            end else begin
                if (wr_en && wr_addr != 5'd0) begin m_reg[wr_addr] = wr_data; m_sb[wr_addr] = 1'b0; end
                if (rsv_en && rsv_addr != 5'd0) m_sb[rsv_addr] = 1'b1;
                if (clr_req) clr_pos = 0;
            end
        end
    end

    initial forever begin
        logic [31:0] d;
        logic        b;
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_port(rd_addr[i*5 +: 5], d, b);
                chk($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(d));
                chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(b));
                chk($sformatf("rdr_busy%0d", i), 64'(rdr_busy[i]), 64'(b));
                chk($sformatf("rdr_data%0d", i), 64'(rdr_data[i*32 +: 32]), 64'(m_rdq[i]));
            end
            chk("clr_busy", 64'(clr_busy), 64'(clr_pos >= 0));
            chk("clr_done", 64'(clr_done), 64'(m_done));
            chk("rdr_clr_busy", 64'(rdr_clr_busy), 64'(clr_pos >= 0));
            chk("rdr_clr_done", 64'(rdr_clr_done), 64'(m_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic do_write(input int a, input logic [31:0] v);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = v;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input int a, input logic [31:0] v, input string name);
        set_rd(a, a);
        @(negedge clk);
        chk(name, rd_data, {v, v});
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt, done_cnt;
        resetn = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        resetn = 1'b1;

        for (int a = 0; a < 32; a++) begin
            set_rd(a, a);
            @(negedge clk);
            chk("reset_read", {rd_data, 30'd0, rd_busy, clr_busy, clr_done}, 96'd0);
            cyc();
        end

        do_write(5, 32'hDEADBEEF);
        read_chk(5, 32'hDEADBEEF, "x5_read");
        do_write(0, 32'h1234);
        read_chk(0, 32'h0, "x0_read");

        set_rd(7, 7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        chk("bypass_x7", 64'(rd_data[31:0]), 64'hA5A5A5A5);
        chk("bypass_busy", 64'(rd_busy), 64'd0);
        cyc();
        wr_en = 1'b0;

        rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        rsv_en = 1'b0;
        set_rd(3, 3);
        @(negedge clk);
        chk("rsv_busy", 64'(rd_busy), 64'd3);
        cyc();
        do_write(3, 32'd9);
        @(negedge clk);
        chk("wr_clears_busy", 64'(rd_busy), 64'd0);
        chk("x3_is_9", rd_data, {32'd9, 32'd9});
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        do_write(3, 32'd11);
        rsv_en = 1'b0;
        @(negedge clk);
        chk("rsv_wr_busy", 64'(rd_busy), 64'd3);
        chk("x3_is_11", rd_data, {32'd11, 32'd11});
        cyc();

        for (int a = 1; a < 32; a++) do_write(a, 32'(a));
        read_chk(17, 32'd17, "fill_x17");
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            cyc();
            wr_en   = (k == 4);
            rsv_en  = (k == 4);
            wr_addr = 5'd9; rsv_addr = 5'd9; wr_data = 32'hFFFF;
        end
        wr_en = 1'b0; rsv_en = 1'b0;
        chk("clear_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("clear_done_pulses", 64'(done_cnt), 64'd1);
        for (int a = 0; a < 32; a++) read_chk(a, 32'd0, "post_clear");
        set_rd(9, 9);
        @(negedge clk);
        chk("x9_not_busy", 64'(rd_busy), 64'd0);
        cyc();

        do_write(5, 32'd55);
        do_write(20, 32'd20);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (9) cyc();
        resetn = 1'b0;
        cyc();
        @(negedge clk);
        chk("abort_busy", 64'(clr_busy), 64'd0);
        chk("abort_done", 64'(clr_done), 64'd0);
        resetn = 1'b1;
        cyc();
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clr_done || clr_busy) done_cnt++;
            cyc();
        end
        chk("abort_no_activity", 64'(done_cnt), 64'd0);
        read_chk(5, 32'd0, "abort_x5");
        read_chk(20, 32'd0, "abort_x20");

        do_write(5, 32'h5555AAAA);
        set_rd(0, 0);
        cyc();
        set_rd(5, 0);
        @(negedge clk);
        chk("regrd_old", 64'(rdr_data[31:0]), 64'd0);
        cyc();
        @(negedge clk);
        chk("regrd_x5", 64'(rdr_data[31:0]), 64'h5555AAAA);
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
